// File: rtl/crypto_core_engine_if.sv
// Command/result bundle between the control unit and the crypto engine.
// The control unit is the master; the engine is the slave.
interface crypto_core_engine_if #(
  parameter int unsigned DATA_W = 16
);
  logic              Load_data;
  logic              start_crypt;
  logic              start_decrypt;
  logic              start_execute_crypto;
  logic              Store_data;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] key_in;
  logic              fin_crypto;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              data_out_en;

  modport master (
    output Load_data, start_crypt, start_decrypt, start_execute_crypto, Store_data,
    output data_in, key_in,
    input  fin_crypto, busy, data_out, data_out_en
  );

  modport slave (
    input  Load_data, start_crypt, start_decrypt, start_execute_crypto, Store_data,
    input  data_in, key_in,
    output fin_crypto, busy, data_out, data_out_en
  );
endinterface

// File: rtl/crypto_core_engine.sv
// Iterative rotate/xor/add block cipher, one round per clock, driven by the
// control unit's load / execute / store pulse sequence.
module crypto_core_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROUNDS = 4
) (
  input logic                 clk,
  input logic                 rst,
  crypto_core_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoaded, StRun, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] key_q;
  logic              decrypt_q;
  logic [7:0]        cnt_q;
  logic              fin_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_out_en_q;

  logic              load_req;
  logic              load_dec;
  int unsigned       rnd_idx;
  int unsigned       rot_amt;
  logic [DATA_W-1:0] round_key;
  logic [DATA_W-1:0] rnd_tmp;
  logic [DATA_W-1:0] x_next;

  assign load_req = bus.Load_data & (bus.start_crypt | bus.start_decrypt);
  // Both mode bits high resolves to encrypt.
  assign load_dec = bus.start_decrypt & ~bus.start_crypt;

  // Decrypt walks the round indices backwards so it undoes encrypt step by step.
  always_comb begin
    rnd_idx   = 0;
    rot_amt   = 0;
    round_key = '0;
    rnd_tmp   = '0;
    x_next    = x_q;
    rnd_idx   = decrypt_q ? (ROUNDS - 1 - 32'(cnt_q)) : 32'(cnt_q);
    rot_amt   = rnd_idx % DATA_W;
    round_key = (key_q << rot_amt) | (key_q >> (DATA_W - rot_amt));
    if (!decrypt_q) begin
      rnd_tmp = (x_q ^ round_key) + DATA_W'(rnd_idx);
      x_next  = {rnd_tmp[DATA_W-4:0], rnd_tmp[DATA_W-1:DATA_W-3]};
    end else begin
      rnd_tmp = {x_q[2:0], x_q[DATA_W-1:3]};
      x_next  = (rnd_tmp - DATA_W'(rnd_idx)) ^ round_key;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      x_q           <= '0;
      key_q         <= '0;
      decrypt_q     <= 1'b0;
      cnt_q         <= '0;
      fin_q         <= 1'b0;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
    end else begin
      data_out_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_req) begin
            x_q       <= bus.data_in;
            key_q     <= bus.key_in;
            decrypt_q <= load_dec;
            state_q   <= StLoaded;
          end
        end
        StLoaded: begin
          if (bus.start_execute_crypto) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else if (load_req) begin
            x_q       <= bus.data_in;
            key_q     <= bus.key_in;
            decrypt_q <= load_dec;
          end
        end
        StRun: begin
          x_q <= x_next;
          if (cnt_q == 8'(ROUNDS - 1)) begin
            data_out_q <= x_next;
            fin_q      <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          if (bus.Store_data) begin
            data_out_en_q <= 1'b1;
            fin_q         <= 1'b0;
            state_q       <= StIdle;
          end else if (load_req) begin
            x_q       <= bus.data_in;
            key_q     <= bus.key_in;
            decrypt_q <= load_dec;
            fin_q     <= 1'b0;
            state_q   <= StLoaded;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fin_crypto  = fin_q;
  assign bus.busy        = busy_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_out_en = data_out_en_q;

endmodule

// File: tb/tb_crypto_core_engine.sv
// Directed bench for crypto_core_engine with DATA_W=16, ROUNDS=4.
module tb_crypto_core_engine;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  crypto_core_engine_if #(.DATA_W(16)) bus ();

  crypto_core_engine #(
    .DATA_W(16),
    .ROUNDS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    int m;
    m = n % 16;
    return (v << m) | (v >> (16 - m));
  endfunction

  function automatic logic [15:0] enc_model(input logic [15:0] d, input logic [15:0] k);
    logic [15:0] x;
    x = d;
    for (int i = 0; i < 4; i++) x = rl((x ^ rl(k, i)) + 16'(i), 3);
    return x;
  endfunction

  function automatic logic [15:0] dec_model(input logic [15:0] d, input logic [15:0] k);
    logic [15:0] x;
    x = d;
    for (int s = 0; s < 4; s++) x = (rl(x, 13) - 16'(3 - s)) ^ rl(k, 3 - s);
    return x;
  endfunction

  task automatic idle_inputs();
    bus.Load_data            = 1'b0;
    bus.start_crypt          = 1'b0;
    bus.start_decrypt        = 1'b0;
    bus.start_execute_crypto = 1'b0;
    bus.Store_data           = 1'b0;
    bus.data_in              = '0;
    bus.key_in               = '0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [15:0] k, input logic c,
                         input logic dc);
    @(negedge clk);
    bus.Load_data     = 1'b1;
    bus.start_crypt   = c;
    bus.start_decrypt = dc;
    bus.data_in       = d;
    bus.key_in        = k;
    @(negedge clk);
    idle_inputs();
  endtask

  // Pulses execute, then counts cycles with busy high (bounded).
  task automatic do_exec(output int cyc);
    @(negedge clk);
    bus.start_execute_crypto = 1'b1;
    @(negedge clk);
    bus.start_execute_crypto = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_store();
    @(negedge clk);
    bus.Store_data = 1'b1;
    @(negedge clk);
    bus.Store_data = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.Load_data            = 1'($urandom);
      bus.start_crypt          = 1'($urandom);
      bus.start_decrypt        = 1'($urandom);
      bus.start_execute_crypto = 1'($urandom);
      bus.Store_data           = 1'($urandom);
      bus.data_in              = 16'($urandom);
      bus.key_in               = 16'($urandom);
    end
    #1;
    total++;
    if ({bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out} !== 19'd0)
      $display("FAIL reset_hold: outputs=%h expected 0",
               {bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out});
    else passed++;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out} !== 19'd0)
      $display("FAIL reset_release: outputs=%h expected 0",
               {bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out});
    else passed++;
  endtask

  task automatic test_encrypt();
    int cyc;
    do_load(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_exec(cyc);
    total++;
    if (cyc !== 4) $display("FAIL enc_busy_cycles: got %0d expected 4", cyc);
    else passed++;
    total++;
    if (bus.fin_crypto !== 1'b1) $display("FAIL enc_fin: got %b expected 1", bus.fin_crypto);
    else passed++;
    total++;
    if (bus.data_out !== 16'h0298)
      $display("FAIL enc_data: got %h expected 0298", bus.data_out);
    else passed++;
  endtask

  task automatic test_store();
    pulse_store();
    total++;
    if ({bus.data_out_en, bus.fin_crypto} !== 2'b10)
      $display("FAIL store_strobe: en,fin=%b%b expected 10", bus.data_out_en, bus.fin_crypto);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.data_out_en !== 1'b0)
      $display("FAIL store_one_cycle: en=%b expected 0", bus.data_out_en);
    else passed++;
    total++;
    if (bus.data_out !== 16'h0298)
      $display("FAIL store_data_hold: got %h expected 0298", bus.data_out);
    else passed++;
  endtask

  task automatic test_decrypt();
    int cyc;
    do_load(16'h0298, 16'h0000, 1'b0, 1'b1);
    do_exec(cyc);
    total++;
    if (cyc !== 4) $display("FAIL dec_busy_cycles: got %0d expected 4", cyc);
    else passed++;
    total++;
    if (bus.data_out !== 16'h0000 || bus.fin_crypto !== 1'b1)
      $display("FAIL dec_data: got %h fin=%b expected 0000 fin=1", bus.data_out, bus.fin_crypto);
    else passed++;
  endtask

  task automatic test_round_trip();
    int cyc;
    logic [15:0] d, k, e;
    for (int n = 0; n < 101; n++) begin
      d = (n == 0) ? 16'h1234 : 16'($urandom);
      k = (n == 0) ? 16'hA5C3 : 16'($urandom);
      do_load(d, k, 1'b1, 1'b0);
      if (n == 0) begin
        total++;
        if (bus.fin_crypto !== 1'b0)
          $display("FAIL load_from_done_fin: got %b expected 0", bus.fin_crypto);
        else passed++;
      end
      do_exec(cyc);
      e = enc_model(d, k);
      total++;
      if (bus.data_out !== e || cyc !== 4)
        $display("FAIL rt_enc[%0d]: got %h cyc=%0d expected %h cyc=4", n, bus.data_out, cyc, e);
      else passed++;
      do_load(e, k, 1'b0, 1'b1);
      do_exec(cyc);
      total++;
      if (bus.data_out !== d || dec_model(e, k) !== d)
        $display("FAIL rt_dec[%0d]: got %h expected %h", n, bus.data_out, d);
      else passed++;
    end
  endtask

  task automatic test_violations();
    int cyc;
    logic [15:0] e;
    // Execute pulse in DONE must not restart.
    do_exec(cyc);
    total++;
    if (cyc !== 0 || bus.fin_crypto !== 1'b1)
      $display("FAIL exec_in_done: busy_cyc=%0d fin=%b expected 0 and 1", cyc, bus.fin_crypto);
    else passed++;
    pulse_store();
    do_exec(cyc);
    total++;
    if (cyc !== 0) $display("FAIL exec_no_load: busy_cyc=%0d expected 0", cyc);
    else passed++;
    do_load(16'h1111, 16'h2222, 1'b0, 1'b0);
    do_exec(cyc);
    total++;
    if (cyc !== 0) $display("FAIL load_no_mode: busy_cyc=%0d expected 0", cyc);
    else passed++;
    // Load during RUN must not disturb the operation in flight.
    do_load(16'h1234, 16'hA5C3, 1'b1, 1'b0);
    @(negedge clk);
    bus.start_execute_crypto = 1'b1;
    @(negedge clk);
    bus.start_execute_crypto = 1'b0;
    do_load(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    e = enc_model(16'h1234, 16'hA5C3);
    total++;
    if (bus.data_out !== e || bus.fin_crypto !== 1'b1)
      $display("FAIL load_in_run: got %h fin=%b expected %h fin=1", bus.data_out,
               bus.fin_crypto, e);
    else passed++;
    do_load(16'h0298, 16'h0000, 1'b1, 1'b1);
    do_exec(cyc);
    e = enc_model(16'h0298, 16'h0000);
    total++;
    if (bus.data_out !== e)
      $display("FAIL both_modes: got %h expected %h", bus.data_out, e);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic seen_en;
    do_load(16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    bus.start_execute_crypto = 1'b1;
    @(negedge clk);
    bus.start_execute_crypto = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out} !== 19'd0)
      $display("FAIL mid_run_reset: outputs=%h expected 0",
               {bus.fin_crypto, bus.busy, bus.data_out_en, bus.data_out});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    seen_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.data_out_en !== 1'b0 || bus.fin_crypto !== 1'b0 || bus.busy !== 1'b0)
        seen_en = 1'b1;
    end
    total++;
    if (seen_en !== 1'b0) $display("FAIL mid_run_quiet: activity=%b expected 0", seen_en);
    else passed++;
    do_load(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_exec(cyc);
    total++;
    if (bus.data_out !== 16'h0298 || cyc !== 4)
      $display("FAIL post_reset_enc: got %h cyc=%0d expected 0298 cyc=4", bus.data_out, cyc);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_encrypt();
    test_store();
    test_decrypt();
    test_round_trip();
    test_violations();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crypto_core_engine.md
# crypto_core_engine

Iterative block cipher engine that responds to the CPU control unit's crypto command sequence. The data/key load (with a crypt or decrypt request), the execute strobe and the result store are each accepted as single-cycle pulses. The engine runs one round per clock, raises `fin_crypto` when the result is ready, and presents the result on `data_out` for write-back to data memory. It sits between the data memory bus and the control unit, as the execution end of the crypto handshake.

## Interface
- `DATA_W`, default 16: data and key width; minimum 4.
- `ROUNDS`, default 4: rounds per operation; legal range 1..255.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `Load_data` in 1: pulse; latch `data_in`, `key_in` and the mode bits.
- `start_crypt` in 1: qualifies `Load_data` as encrypt.
- `start_decrypt` in 1: qualifies `Load_data` as decrypt.
- `start_execute_crypto` in 1: pulse; begin rounds on latched operands.
- `Store_data` in 1: pulse; acknowledge the result and release the engine.
- `data_in` in DATA_W: operand from the data memory read bus.
- `key_in` in DATA_W: key operand.
- `fin_crypto` out 1: result ready; level signal.
- `busy` out 1: high while rounds execute.
- `data_out` out DATA_W: result register.
- `data_out_en` out 1: one-cycle strobe; `data_out` is to be driven onto the memory write bus.

## Operation
- States are IDLE, LOADED, RUN and DONE.
- **Reset:** rst low clears everything immediately: state IDLE, `fin_crypto`=0, `busy`=0, `data_out`=0, `data_out_en`=0, latched data/key/mode=0, round counter=0.
- **IDLE or DONE → LOADED:** on `Load_data` with (`start_crypt` | `start_decrypt`).
  - Latch `data_in` into working register x and latch `key_in`.
  - Mode is decrypt only if `start_decrypt` & ~`start_crypt`. Both high means encrypt.
  - Leaving DONE this way clears `fin_crypto`.
  - `Load_data` with neither mode bit is ignored.
- **LOADED:** a new qualified `Load_data` re-latches the operands. `start_execute_crypto` → RUN with counter=0.
- **Ignored pulses:**
  - `start_execute_crypto` in IDLE, RUN or DONE is ignored.
  - `Load_data` in RUN is ignored.
  - `Store_data` outside DONE is ignored.
- **Round keys:** k_i = rotl(key, i mod DATA_W).
- **Encrypt round i, for i = 0..ROUNDS-1:** x ← rotl3((x ^ k_i) + i) mod 2^DATA_W.
- **Decrypt round step s, for s = 0..ROUNDS-1:** uses j = ROUNDS-1-s. x ← (rotr3(x) − j mod 2^DATA_W) ^ k_j.
- Decrypt with the same key exactly inverts encrypt.
- **RUN:** one round per clock. On the edge applying the last round:
  - `data_out` ← new x;
  - state → DONE;
  - `fin_crypto` ← 1;
  - `busy` ← 0.
- **DONE:** `fin_crypto` holds 1 until `Store_data`, or until a qualified `Load_data` (handled as IDLE → LOADED).
- **`Store_data` in DONE:**
  - `data_out_en` ← 1 for one cycle;
  - `fin_crypto` ← 0;
  - state → IDLE.
- `data_out` keeps its value until the next completed operation, so a memory write one or more cycles after `Store_data` sees a stable result.

## Timing
- All outputs are registered. No input reaches an output combinationally.
- **Load:** `Load_data` sampled at edge E → LOADED after E.
- **Execute:** `start_execute_crypto` sampled at edge E0 → `busy`=1 after E0. Rounds are applied at E1..E_ROUNDS.
  - `fin_crypto`=1 and valid `data_out` appear after E_ROUNDS.
  - `busy` is high for exactly ROUNDS cycles.
- `fin_crypto` may be sampled combinationally by the control unit. It must not glitch.
- **Store:** `Store_data` sampled at edge E → `data_out_en`=1 and `fin_crypto`=0 during the cycle after E; `data_out_en`=0 after E+1.
- **Simultaneous events:**
  - `Load_data` with `start_execute_crypto` in IDLE: only the load takes effect.
  - In LOADED, execute has priority over load.
  - In DONE, `Store_data` has priority over `Load_data`.
- **Reset mid-RUN:** the operation is aborted with no output pulse. The next sequence behaves as from power-up.

## Test plan
- **Reset:** hold rst=0 with random inputs → all outputs 0. Release rst → still 0, state IDLE.
- **Encrypt:** ROUNDS=4; Load_data+start_crypt with data_in=0x0000, key_in=0x0000; then start_execute_crypto → `busy` high 4 cycles, then `fin_crypto`=1 and `data_out`=0x0298.
- **Decrypt:** Load_data+start_decrypt with data_in=0x0298, key_in=0x0000; then execute → `data_out`=0x0000 after 4 busy cycles.
- **Round-trip:** encrypt 0x1234 with key 0xA5C3, then decrypt that result with the same key → `data_out`=0x1234. Repeat for 100 random pairs.
- **Store handshake:** in DONE, pulse Store_data → `data_out_en` high exactly one cycle, `fin_crypto` falls the same cycle, `data_out` unchanged afterward.
- **Violations and reset:**
  - execute with no prior load → no `busy`;
  - Load_data during RUN → result unaffected;
  - both mode bits high → encrypt result;
  - rst low in the 2nd RUN cycle → outputs 0, and the following encrypt of 0/0 again yields 0x0298.
